print_sched: RTL and testbench

//  Round-robin scheduler that shares one print chain (string fetch -> FIFO -> UART tx) among N requesters.

---
 rtl/print_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/print_sched.sv | 190 +++++++++++++++++++
 tb/tb_print_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/print_pkg.sv
// Shared types and constants for the print-chain scheduler.
// The optional CR/LF trailer is enabled by defining PRINT_SCHED_NEWLINE_EN.
package print_pkg;

  // Scheduler states. CR and LF are only reached when the newline trailer is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    CR     = 3'd4,
    LF     = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting one slot after ptr,
// wrapping around, and returns the first requester found. The pointer register
// itself lives in the caller.
module rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int REQ_L2 = 2
) (
  input  logic [N_REQ-1:0]  req_i,
  input  logic [REQ_L2-1:0] ptr_i,
  input  logic              en_i,
  output logic [N_REQ-1:0]  grant_o,
  output logic [REQ_L2-1:0] idx_o,
  output logic              valid_o
);

  // Walk the slots in priority order (ptr+1, ptr+2, ... ptr) and keep the first hit.
  always_comb begin
    int                slot;
    logic [REQ_L2-1:0] slot_idx;
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      slot = int'(ptr_i) + i;
      if (slot >= N_REQ) slot = slot - N_REQ;
      slot_idx = slot[REQ_L2-1:0];
      if (en_i && !valid_o && req_i[slot_idx]) begin
        valid_o           = 1'b1;
        grant_o[slot_idx] = 1'b1;
        idx_o             = slot_idx;
      end
    end
  end

endmodule

// File: rtl/print_sched.sv
// Round-robin scheduler sharing one print chain among N_REQ requesters.
// Each grant runs one job (RAM string or single bypass byte) through the
// chain's start/ready handshake and then pulses done_o to the owner.
// Define PRINT_SCHED_NEWLINE_EN to append a CR/LF pair after every string job.
module print_sched #(
  parameter int N_REQ    = 4,
  parameter int REQ_L2   = 2,
  parameter int ADDR_WID = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        req_bypass_i,
  input  logic [N_REQ*ADDR_WID-1:0] req_start_i,
  input  logic [N_REQ*ADDR_WID-1:0] req_end_i,
  input  logic [N_REQ*8-1:0]      req_byte_i,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    busy_o,
  output logic [REQ_L2-1:0]       grant_idx_o,
  output logic                    chain_en_o,
  output logic [ADDR_WID-1:0]     chain_addr_start_o,
  output logic [ADDR_WID-1:0]     chain_addr_end_o,
  output logic                    chain_bypass_o,
  output logic [7:0]              chain_bypass_data_o,
  input  logic                    chain_ready_i
);
  import print_pkg::*;

`ifdef PRINT_SCHED_NEWLINE_EN
  // Which part of the job the current handshake belongs to.
  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_CR   = 2'd1;
  localparam logic [1:0] PH_LF   = 2'd2;
  logic [1:0] phase_q;
`endif

  state_t              state_q;
  logic [REQ_L2-1:0]   ptr_q;
  logic [REQ_L2-1:0]   grant_idx_q;
  logic [N_REQ-1:0]    owner_q;
  logic [N_REQ-1:0]    done_q;
  logic [N_REQ-1:0]    err_q;
  logic                chain_en_q;
  logic [ADDR_WID-1:0] start_q;
  logic [ADDR_WID-1:0] end_q;
  logic                bypass_q;
  logic [7:0]          data_q;

  logic [N_REQ-1:0]    arb_grant;
  logic [REQ_L2-1:0]   arb_idx;
  logic                arb_valid;

  // Per-slot views of the packed payload buses.
  logic [ADDR_WID-1:0] slot_start [N_REQ];
  logic [ADDR_WID-1:0] slot_end   [N_REQ];
  logic [7:0]          slot_byte  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign slot_start[gi] = req_start_i[gi*ADDR_WID +: ADDR_WID];
      assign slot_end[gi]   = req_end_i[gi*ADDR_WID +: ADDR_WID];
      assign slot_byte[gi]  = req_byte_i[gi*8 +: 8];
    end
  endgenerate

  logic [ADDR_WID-1:0] sel_start;
  logic [ADDR_WID-1:0] sel_end;
  logic [7:0]          sel_byte;
  logic                sel_bypass;
  logic                sel_reject;

  assign sel_start  = slot_start[arb_idx];
  assign sel_end    = slot_end[arb_idx];
  assign sel_byte   = slot_byte[arb_idx];
  assign sel_bypass = req_bypass_i[arb_idx];
  // An empty-or-backwards string range is refused without touching the chain.
  assign sel_reject = !sel_bypass && (sel_start > sel_end);

  rr_arbiter #(
    .N_REQ  (N_REQ),
    .REQ_L2 (REQ_L2)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Job FSM: grant and capture, chain handshake, optional CR/LF trailer, completion pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_L2'(N_REQ - 1);
      grant_idx_q <= '0;
      owner_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      chain_en_q  <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      bypass_q    <= 1'b0;
      data_q      <= '0;
`ifdef PRINT_SCHED_NEWLINE_EN
      phase_q     <= PH_MAIN;
`endif
    end else begin
      chain_en_q <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            ptr_q       <= arb_idx;
            grant_idx_q <= arb_idx;
            owner_q     <= arb_grant;
            start_q     <= sel_start;
            end_q       <= sel_end;
            bypass_q    <= sel_bypass;
            data_q      <= sel_byte;
`ifdef PRINT_SCHED_NEWLINE_EN
            phase_q     <= PH_MAIN;
`endif
            if (sel_reject) begin
              done_q  <= arb_grant;
              err_q   <= arb_grant;
              state_q <= DONE;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (chain_ready_i) begin
            chain_en_q <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        // The chain needs a cycle to drop ready after the start pulse.
        SETTLE: state_q <= WAIT;
        WAIT: begin
          if (chain_ready_i) begin
`ifdef PRINT_SCHED_NEWLINE_EN
            if (phase_q == PH_MAIN && !bypass_q) begin
              state_q <= CR;
            end else if (phase_q == PH_CR) begin
              state_q <= LF;
            end else begin
              done_q  <= owner_q;
              state_q <= DONE;
            end
`else
            done_q  <= owner_q;
            state_q <= DONE;
`endif
          end
        end
`ifdef PRINT_SCHED_NEWLINE_EN
        CR: begin
          bypass_q <= 1'b1;
          data_q   <= CHAR_CR;
          phase_q  <= PH_CR;
          state_q  <= ISSUE;
        end
        LF: begin
          bypass_q <= 1'b1;
          data_q   <= CHAR_LF;
          phase_q  <= PH_LF;
          state_q  <= ISSUE;
        end
`endif
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o              = (state_q != IDLE);
  assign grant_idx_o         = grant_idx_q;
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign chain_en_o          = chain_en_q;
  assign chain_addr_start_o  = start_q;
  assign chain_addr_end_o    = end_q;
  assign chain_bypass_o      = bypass_q;
  assign chain_bypass_data_o = data_q;

endmodule

// File: tb/tb_print_sched.sv
// Bench for print_sched: randomized requesters and a stalling chain model,
// checked against a job-level reference (round-robin pick, captured payload,
// expected number of chain starts per job). Honours PRINT_SCHED_NEWLINE_EN.
module tb_print_sched;

  localparam int AGE_MAX = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_v;
  logic [3:0]  byp_v;
  logic [27:0] req_start;
  logic [27:0] req_end;
  logic [31:0] req_byte;
  logic        ready_v;
  logic [3:0]  done_o;
  logic [3:0]  err_o;
  logic        busy_o;
  logic [1:0]  grant_idx_o;
  logic        chain_en_o;
  logic [6:0]  chain_addr_start_o;
  logic [6:0]  chain_addr_end_o;
  logic        chain_bypass_o;
  logic [7:0]  chain_bypass_data_o;

  logic [6:0]  p_s [4];
  logic [6:0]  p_e [4];
  logic [7:0]  p_b [4];

  always #5 clk = ~clk;

  always_comb begin
    req_start = '0;
    req_end   = '0;
    req_byte  = '0;
    for (int k = 0; k < 4; k++) begin
      req_start[k*7 +: 7] = p_s[k];
      req_end[k*7 +: 7]   = p_e[k];
      req_byte[k*8 +: 8]  = p_b[k];
    end
  end

  print_sched #(.N_REQ(4), .REQ_L2(2), .ADDR_WID(7)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_i               (req_v),
    .req_bypass_i        (byp_v),
    .req_start_i         (req_start),
    .req_end_i           (req_end),
    .req_byte_i          (req_byte),
    .done_o              (done_o),
    .err_o               (err_o),
    .busy_o              (busy_o),
    .grant_idx_o         (grant_idx_o),
    .chain_en_o          (chain_en_o),
    .chain_addr_start_o  (chain_addr_start_o),
    .chain_addr_end_o    (chain_addr_end_o),
    .chain_bypass_o      (chain_bypass_o),
    .chain_bypass_data_o (chain_bypass_data_o),
    .chain_ready_i       (ready_v)
  );

  int n_cmp;
  int n_bad;
  int n_jobs;

  // Reference state (job level)
  logic [1:0] last_ptr;
  logic [1:0] gidx_m;
  logic [1:0] owner;
  bit         active;
  bit         can_grant;
  bit         j_byp;
  bit         j_rej;
  logic [6:0] j_s;
  logic [6:0] j_e;
  logic [7:0] j_b;
  int         pulses;
  int         age;
  bit         prev_en;
  int         chain_cnt;
  int         stall;
  bit         quiet;
  bit         blocked [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round robin: first pending slot after the last winner, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] k;
    for (int i = 1; i <= 4; i++) begin
      k = last + 2'(i);
      if (r[k]) return k;
    end
    return last;
  endfunction

  function automatic int exp_pulses();
    if (j_rej) return 0;
    if (j_byp) return 1;
`ifdef PRINT_SCHED_NEWLINE_EN
    return 3;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    active    = 0;
    can_grant = 1;
    last_ptr  = 2'd3;
    gidx_m    = 2'd0;
    owner     = 2'd0;
    pulses    = 0;
    age       = 0;
    prev_en   = 0;
    chain_cnt = 0;
    stall     = 0;
    ready_v   = 1'b1;
    req_v     = 4'b0;
    for (int k = 0; k < 4; k++) blocked[k] = 0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_val({tag, "_done"}, 32'(done_o), 32'd0);
    check_val({tag, "_err"}, 32'(err_o), 32'd0);
    check_val({tag, "_gidx"}, 32'(grant_idx_o), 32'd0);
    check_val({tag, "_en"}, 32'(chain_en_o), 32'd0);
    check_val({tag, "_start"}, 32'(chain_addr_start_o), 32'd0);
    check_val({tag, "_end"}, 32'(chain_addr_end_o), 32'd0);
    check_val({tag, "_byp"}, 32'(chain_bypass_o), 32'd0);
    check_val({tag, "_data"}, 32'(chain_bypass_data_o), 32'd0);
  endtask

  task automatic new_job(input logic [1:0] k);
    int s;
    int e;
    s = $urandom_range(0, 120);
    case ($urandom_range(0, 5))
      0: e = (s > 0) ? $urandom_range(0, s - 1) : 5;
      1: e = s;
      default: e = $urandom_range(s, 127);
    endcase
    byp_v[k] = 1'($urandom_range(0, 1));
    p_s[k]   = 7'(s);
    p_e[k]   = 7'(e);
    p_b[k]   = 8'($urandom_range(0, 255));
    req_v[k] = 1'b1;
  endtask

  task automatic drive_inputs();
    logic [1:0] kk;
    if (chain_cnt > 0) begin
      ready_v = 1'b0;
      chain_cnt--;
    end else if (stall > 0) begin
      ready_v = 1'b0;
      stall--;
    end else begin
      ready_v = 1'b1;
      if ($urandom_range(0, 15) == 0) stall = $urandom_range(1, 20);
    end
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      if (active && owner == kk) begin
        // Payload after grant must not matter; the owner may also let go early.
        p_s[kk]   = 7'($urandom_range(0, 127));
        p_e[kk]   = 7'($urandom_range(0, 127));
        p_b[kk]   = 8'($urandom_range(0, 255));
        byp_v[kk] = 1'($urandom_range(0, 1));
        if (req_v[kk] && $urandom_range(0, 19) == 0) req_v[kk] = 1'b0;
      end else if (!req_v[kk] && !blocked[kk] && !quiet && $urandom_range(0, 7) == 0) begin
        new_job(kk);
      end
      blocked[kk] = 0;
    end
  endtask

  // One clock: sample just after the edge, update the reference, drive next inputs.
  task automatic step();
    logic [1:0] w;
    bit         done_seen;
    @(posedge clk);
    #1;
    done_seen = 0;
    if (can_grant && req_v != 4'b0) begin
      w        = rr_pick(req_v, last_ptr);
      last_ptr = w;
      gidx_m   = w;
      owner    = w;
      active   = 1;
      j_byp    = byp_v[w];
      j_s      = p_s[w];
      j_e      = p_e[w];
      j_b      = p_b[w];
      j_rej    = !j_byp && (j_s > j_e);
      pulses   = 0;
      age      = 0;
      if (j_rej) check_val("rej_same_cycle", 32'(done_o), 32'(4'b0001 << w));
    end
    check_val("busy", 32'(busy_o), 32'(active));
    check_val("grant_idx", 32'(grant_idx_o), 32'(gidx_m));
    if (chain_en_o) begin
      check_val("en_without_job", 32'(active), 32'd1);
      check_val("en_while_not_ready", 32'(ready_v), 32'd1);
      check_val("en_width", 32'(prev_en), 32'd0);
      check_val("en_count", 32'(pulses < exp_pulses()), 32'd1);
      if (pulses == 0) begin
        check_val("en_bypass", 32'(chain_bypass_o), 32'(j_byp));
        if (j_byp) begin
          check_val("en_byte", 32'(chain_bypass_data_o), 32'(j_b));
        end else begin
          check_val("en_start", 32'(chain_addr_start_o), 32'(j_s));
          check_val("en_end", 32'(chain_addr_end_o), 32'(j_e));
        end
      end else begin
        check_val("nl_bypass", 32'(chain_bypass_o), 32'd1);
        check_val("nl_byte", 32'(chain_bypass_data_o), (pulses == 1) ? 32'h0D : 32'h0A);
      end
      pulses++;
      chain_cnt = $urandom_range(1, 6);
    end
    prev_en = chain_en_o;
    if (done_o != 4'b0 || err_o != 4'b0) begin
      check_val("done_owner", 32'(done_o), active ? 32'(4'b0001 << owner) : 32'd0);
      check_val("err", 32'(err_o), (active && j_rej) ? 32'(4'b0001 << owner) : 32'd0);
      check_val("pulse_total", 32'(pulses), active ? 32'(exp_pulses()) : 32'd0);
      n_jobs++;
      $display("job %0d: slot=%0d bypass=%0d start=%0d end=%0d byte=%02h starts=%0d err=%0b t=%0t",
               n_jobs, owner, j_byp, j_s, j_e, j_b, pulses, err_o != 4'b0, $time);
      if (active) begin
        req_v[owner]   = 1'b0;
        blocked[owner] = 1;
        active         = 0;
        done_seen      = 1;
      end
    end
    if (active) begin
      age++;
      if (age > AGE_MAX) begin
        check_val("job_timeout", 32'(age), 32'(AGE_MAX));
        active = 0;
      end
    end
    can_grant = !active && !done_seen;
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int max_steps);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_steps; i++) begin
      step();
      if (!active && req_v == 4'b0) begin
        ok = 1;
        break;
      end
    end
    check_val({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    bit found;
    n_cmp  = 0;
    n_bad  = 0;
    n_jobs = 0;
    quiet  = 1;
    rst    = 1'b0;
    byp_v  = 4'b0;
    for (int k = 0; k < 4; k++) begin
      p_s[k] = '0;
      p_e[k] = '0;
      p_b[k] = '0;
    end
    model_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All four ask at once: served 0,1,2,3.
    for (int k = 0; k < 4; k++) begin
      byp_v[k] = 1'b0;
      p_s[k]   = 7'(8 * k);
      p_e[k]   = 7'(8 * k + 3);
    end
    req_v = 4'hF;
    run_until_idle("all_four", 600);

    // Backwards range on slot 3 is rejected.
    byp_v[3] = 1'b0;
    p_s[3]   = 7'd40;
    p_e[3]   = 7'd10;
    req_v    = 4'b1000;
    run_until_idle("reject", 50);

    // Slot 2 string 16..23 behind a 20-cycle chain stall.
    byp_v[2] = 1'b0;
    p_s[2]   = 7'd16;
    p_e[2]   = 7'd23;
    stall    = 20;
    req_v    = 4'b0100;
    run_until_idle("single", 300);

    // Bypass byte 8'h41: one chain start only.
    byp_v[1] = 1'b1;
    p_b[1]   = 8'h41;
    req_v    = 4'b0010;
    run_until_idle("bypass", 200);

    quiet = 0;
    repeat (3000) step();

    // Reset in the middle of a job.
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (active && pulses >= 1) begin
        found = 1;
        break;
      end
    end
    check_val("reach_job_timeout", 32'(found), 32'd1);
    step();
    #2 rst = 1'b1;
    #1 check_zero("midjob_reset");
    repeat (2) @(posedge clk);
    #1;
    quiet = 1;
    model_reset();
    rst = 1'b0;
    byp_v[0] = 1'b1;
    p_b[0]   = 8'h55;
    req_v    = 4'b0001;
    run_until_idle("after_reset", 200);

    quiet = 0;
    repeat (1500) step();
    quiet = 1;
    run_until_idle("drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
